// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM state, store/load encodings and index-width helper
package data_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic WE_STORE = 1'b1;
    localparam logic WE_LOAD  = 1'b0;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: byte-enable word RAM with registered read data, no reset
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    mask,
    input  logic [IW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (mask[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: request/valid data memory with programmable completion latency
// The array access happens on the edge that enters RESP, so a reset before then drops the store.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        valid,
    output logic [31:0] load_data,
    output logic        busy
);

    localparam int IW = idx_width(DEPTH);
    localparam logic [3:0] LAT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          cap_we;
    logic [3:0]    cap_mask;
    logic [IW-1:0] cap_idx;
    logic [31:0]   cap_data;
    logic          accept, en, idle;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign idle        = state == IDLE;
    assign accept      = idle && request;
    assign unused_bits = ^{address[31:IW+2], address[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_we   <= WE_LOAD;
            cap_mask <= '0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                cap_we   <= we_re;
                cap_mask <= mask;
                cap_idx  <= address[IW+1:2];
                cap_data <= store_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        en      = 1'b0;
        case (state)
            IDLE: if (request) begin
                state_n = LATENCY > 1 ? WAIT : RESP;
                cnt_n   = LAT_INIT;
                en      = LATENCY == 1;
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == 4'd0) begin
                    state_n = RESP;
                    cnt_n   = '0;
                    en      = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // With LATENCY=1 the access coincides with capture, so use the live inputs while idle
    data_mem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clk   (clk),
        .en    (en),
        .we    (idle ? we_re : cap_we),
        .mask  (idle ? mask : cap_mask),
        .index (idle ? address[IW+1:2] : cap_idx),
        .wdata (idle ? store_data : cap_data),
        .rdata (rdata)
    );

    assign valid     = state == RESP;
    assign busy      = !rst && (!idle || request);
    assign load_data = (valid && cap_we == WE_LOAD) ? rdata : '0;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data-memory responder that sits on the far side of the core's data-memory port. It accepts one request per transaction (`request`, `we_re`, `mask`, `address`, `store_data`) and completes it after a programmable latency. It returns a single-cycle `valid` pulse, with read data on loads. It serves as the behavioural/FPGA-block-RAM data memory for the 5-stage pipeline, whose memory stage stalls until `valid`.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: clock edges from request acceptance to the `valid` rising edge; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `request`  in  1  transaction request; held stable by the core until `valid`.
- `we_re`  in  1  1 = store (write), 0 = load (read).
- `mask`  in  4  byte enables; bit i selects byte lane i (bits [8i+7:8i]).
- `address`  in  32  byte address; word index = `address[log2(DEPTH)+1:2]`. `address[1:0]` and the upper bits are ignored.
- `store_data`  in  32  write data, already lane-aligned by the core.
- `valid`  out  1  one-cycle completion pulse.
- `load_data`  out  32  read word; meaningful only while `valid`=1 and the transaction was a load.
- `busy`  out  1  high from acceptance until the cycle `valid` is high, inclusive.

## Operation
- FSM states:
  - IDLE: `request`=1 captures `we_re`, `mask`, word index and `store_data` into holding registers. Goes to WAIT if `LATENCY`>1, else to RESP. `request`=0 stays in IDLE.
  - WAIT: down-counter is loaded with `LATENCY`-2 on entry and decrements each cycle. At 0 it goes to RESP.
  - RESP: `valid`=1 for exactly this cycle, then unconditionally goes to IDLE.
- Only captured values are used. Input changes after acceptance are ignored.
- Store: the write commits on the edge that enters RESP. Only bytes with `mask` bit=1 are written. `mask`=0000 still completes with `valid` and leaves memory unchanged. `load_data` is 0 for stores.
- Load: the full 32-bit word is read on the edge entering RESP and registered into `load_data`. `mask` does not affect read data; lane extraction and sign extension belong to the core's memory stage.
- A request held high during RESP is not re-accepted. The core must drop `request` in the `valid` cycle. A request still high in the following IDLE cycle starts a new transaction.
- Index wraps modulo `DEPTH`. Addresses outside the array alias; no error is raised.

## Timing
- Reset values: `valid`=0, `load_data`=0, `busy`=0, FSM=IDLE, counter=0.
- Memory contents are not cleared by `rst`.
- Request sampled at edge k:
  - `valid` is high from edge k+`LATENCY` to edge k+`LATENCY`+1.
  - `busy` is high from edge k to edge k+`LATENCY`+1.
- Peak throughput: one transaction per `LATENCY`+1 cycles.
- `rst` asserted mid-transaction: FSM returns to IDLE immediately and the pending store is dropped (no write). `valid` deasserts asynchronously.
- `rst` deasserted with `request` already high: the request is accepted on the first rising edge after deassertion.
- A read of a word written by the immediately preceding transaction returns the new data.

## Structure
- Shared package `data_mem_pkg` holds:
  - FSM state enum (IDLE, WAIT, RESP);
  - constants `WE_STORE`=1'b1 and `WE_LOAD`=1'b0;
  - helper function computing the index width from `DEPTH`.
- Sub-module `data_mem_array`: byte-enable word RAM with write-enable, 4-bit byte-write mask, index, write data and registered read data. No reset on the array.
- `data_mem_responder` owns the FSM, latency counter and capture registers.

## Test plan
- Reset: assert `rst` mid-WAIT of a store (0x100, `store_data`=0xDEADBEEF, `mask`=1111) -> `valid`=0; a later load of 0x100 returns the pre-reset contents, not 0xDEADBEEF.
- Full-word round trip: `LATENCY`=2, store 0xCAFEF00D at 0x40 -> `valid` 2 edges after acceptance, `load_data`=0. Load 0x40 -> `load_data`=0xCAFEF00D.
- Byte masking: store 0x11223344 at 0x80 with `mask`=1111, then 0xAABBCCDD with `mask`=0101 -> load returns 0x11BB33DD.
- Latency sweep: `LATENCY`=1 and 15 -> `valid` exactly 1 and 15 edges after acceptance. `busy` spans acceptance through `valid`. Exactly one pulse per transaction.
- Held request: keep `request` high continuously with `LATENCY`=3 -> `valid` every 4 cycles; no duplicate in the RESP cycle.
- Aliasing and ignored inputs: `DEPTH`=1024, store at 0x1004, load 0x0004 -> same data. Changing `address` and `store_data` during WAIT has no effect on the completed transaction.
